hack_fetch_sequencer: RTL and testbench

- Multi-cycle control unit for the Hack CPU.
- Sequences instruction fetch from instruction memory, latches and decodes each instruction, and evaluates the jump condition from the ALU flags.
- Drives the PC's reset/load/inc strobes and the A/D/M write enables.
- Sits between the instruction-memory port, the ALU/register datapath and the 16-bit PC register.

---
 rtl/hack_pkg.sv | 21 ++
 rtl/hack_fetch_sequencer_if.sv | 31 +++
 rtl/hack_jump_eval.sv | 13 +
 rtl/hack_fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_hack_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack fetch sequencer
// and its reference model.
package hack_pkg;

   typedef enum logic [2:0] {
      StBoot,
      StIdle,
      StFetch,
      StExec,
      StFault
   } state_e;

   localparam int unsigned CI_BIT = 15;
   localparam int unsigned DEST_A = 5;
   localparam int unsigned DEST_D = 4;
   localparam int unsigned DEST_M = 3;
   localparam int unsigned J_LT   = 2;
   localparam int unsigned J_EQ   = 1;
   localparam int unsigned J_GT   = 0;

endpackage

// File: rtl/hack_fetch_sequencer_if.sv
// Instruction-memory, ALU-flag and datapath-strobe bundle of the fetch sequencer.
interface hack_fetch_sequencer_if;

   logic        imem_req;
   logic        imem_valid;
   logic [15:0] imem_data;
   logic        alu_zr;
   logic        alu_ng;
   logic        dmem_busy;
   logic [15:0] instr;
   logic        instr_valid;
   logic        pc_reset;
   logic        pc_load;
   logic        pc_inc;
   logic        a_load;
   logic        d_load;
   logic        m_write;

   modport master (
      output imem_req, instr, instr_valid, pc_reset, pc_load, pc_inc,
             a_load, d_load, m_write,
      input  imem_valid, imem_data, alu_zr, alu_ng, dmem_busy
   );

   modport slave (
      input  imem_req, instr, instr_valid, pc_reset, pc_load, pc_inc,
             a_load, d_load, m_write,
      output imem_valid, imem_data, alu_zr, alu_ng, dmem_busy
   );

endinterface

// File: rtl/hack_jump_eval.sv
// Hack jump-condition evaluation from the j-field of a C-instruction and ALU flags.
module hack_jump_eval
   import hack_pkg::*;
(
   input  logic [2:0] j,
   input  logic       zr,
   input  logic       ng,
   output logic       jump
);

   assign jump = (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_fetch_sequencer.sv
// Multi-cycle Hack CPU control: fetch, latch/decode, jump evaluation and
// PC / register / memory strobe generation.
module hack_fetch_sequencer
   import hack_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned RETIRE_W    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic                  fault,
   output logic [RETIRE_W-1:0]   retired,
   hack_fetch_sequencer_if.master bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [15:0]         instr_q, instr_d;
   logic                fault_q, fault_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                jump;

   logic imem_req, instr_valid, pc_reset, pc_load, pc_inc, a_load, d_load, m_write;

   hack_jump_eval u_jump_eval (
      .j    (instr_q[J_LT:J_GT]),
      .zr   (bus.alu_zr),
      .ng   (bus.alu_ng),
      .jump (jump)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      instr_d     = instr_q;
      fault_d     = fault_q;
      retired_d   = retired_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      pc_reset    = 1'b0;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      a_load      = 1'b0;
      d_load      = 1'b0;
      m_write     = 1'b0;

      unique case (state_q)
         StBoot: begin
            pc_reset = 1'b1;
            state_d  = run ? StFetch : StIdle;
         end
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (bus.imem_valid) begin
               instr_d = bus.imem_data;
               cnt_d   = '0;
               state_d = StExec;
            end else if (cnt_q >= CntLast) begin
               cnt_d   = '0;
               fault_d = 1'b1;
               state_d = StFault;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StExec: begin
            instr_valid = 1'b1;
            if (!bus.dmem_busy) begin
               if (instr_q[CI_BIT]) begin
                  a_load  = instr_q[DEST_A];
                  d_load  = instr_q[DEST_D];
                  m_write = instr_q[DEST_M];
                  pc_load = jump;
                  pc_inc  = ~jump;
               end else begin
                  a_load = 1'b1;
                  pc_inc = 1'b1;
               end
               retired_d = retired_q + 1'b1;
               state_d   = run ? StFetch : StIdle;
            end
         end
         StFault: begin
         end
         default: state_d = StBoot;
      endcase

      // Reset suppresses every strobe so nothing commits on the reset edge.
      if (reset) begin
         imem_req    = 1'b0;
         instr_valid = 1'b0;
         pc_reset    = 1'b0;
         pc_load     = 1'b0;
         pc_inc      = 1'b0;
         a_load      = 1'b0;
         d_load      = 1'b0;
         m_write     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StBoot;
         cnt_q     <= '0;
         instr_q   <= '0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         instr_q   <= instr_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign bus.imem_req    = imem_req;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid;
   assign bus.pc_reset    = pc_reset;
   assign bus.pc_load     = pc_load;
   assign bus.pc_inc      = pc_inc;
   assign bus.a_load      = a_load;
   assign bus.d_load      = d_load;
   assign bus.m_write     = m_write;
   assign fault           = fault_q;
   assign retired         = retired_q;

endmodule

// File: tb/tb_hack_fetch_sequencer.sv
// Scoreboard bench for hack_fetch_sequencer: stimulus queues expected commit
// strobes, a negedge monitor checks every commit and stall cycle.
module tb_hack_fetch_sequencer;

   localparam int unsigned RetireW = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic               run;
   logic               fault;
   logic [RetireW-1:0] retired;

   hack_fetch_sequencer_if bus ();

   hack_fetch_sequencer #(
      .TIMEOUT_CYC (4),
      .RETIRE_W    (RetireW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .fault   (fault),
      .retired (retired),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_ret  = 0;

   // {instr, a_load, d_load, m_write, pc_load, pc_inc}
   logic [20:0] sb[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] strobes();
      return {bus.pc_reset, bus.pc_load, bus.pc_inc, bus.a_load, bus.d_load,
              bus.m_write, bus.imem_req, bus.instr_valid};
   endfunction

   always @(negedge clk) begin
      logic [20:0] exp;
      if (bus.instr_valid) begin
         if (bus.dmem_busy) begin
            chk("stall_strobes", {27'd0, bus.a_load, bus.d_load, bus.m_write, bus.pc_load,
                bus.pc_inc}, 32'd0);
         end else if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_commit: got instr %h required no commit", bus.instr);
         end else begin
            exp = sb.pop_front();
            chk("commit", {11'd0, bus.instr, bus.a_load, bus.d_load, bus.m_write,
                bus.pc_load, bus.pc_inc}, {11'd0, exp});
         end
      end
   end

   // Starts in IDLE; run drops in FETCH so the block returns to IDLE after commit.
   task automatic run_one(input logic [15:0] word, input logic zr, input logic ng,
                          input int busy, input logic [4:0] exp5);
      sb.push_back({word, exp5});
      run = 1'b1;
      tick();
      chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
      run            = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_data  = word;
      tick();
      bus.imem_valid = 1'b0;
      bus.alu_zr     = zr;
      bus.alu_ng     = ng;
      for (int i = 0; i < busy; i++) begin
         bus.dmem_busy = 1'b1;
         tick();
         chk("exec_held", {31'd0, bus.instr_valid}, 32'd1);
      end
      bus.dmem_busy = 1'b0;
      tick();
      exp_ret++;
      chk("idle_after", {24'd0, strobes()}, 32'd0);
      chk("retired", retired, exp_ret);
   endtask

   initial begin
      int cyc;
      reset          = 1'b1;
      run            = 1'b1;
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'h0005;
      bus.alu_zr     = 1'b0;
      bus.alu_ng     = 1'b0;
      bus.dmem_busy  = 1'b0;

      // Back-to-back A-instructions with imem_valid tied high.
      tick();
      reset = 1'b0;
      repeat (3) sb.push_back({16'h0005, 5'b10001});
      @(negedge clk);
      chk("boot_strobes", {24'd0, strobes()}, 32'h80);
      chk("boot_retired", retired, 32'd0);
      chk("boot_fault", {31'd0, fault}, 32'd0);
      chk("boot_instr", {16'd0, bus.instr}, 32'd0);
      tick();
      chk("first_fetch", {24'd0, strobes()}, 32'h02);
      tick();
      chk("exec_instr", {16'd0, bus.instr}, 32'h0005);
      chk("exec_valid", {31'd0, bus.instr_valid}, 32'd1);
      tick();
      chk("retired_1", retired, 32'd1);
      tick();
      tick();
      chk("retired_2", retired, 32'd2);
      tick();
      run = 1'b0;
      tick();
      exp_ret = 3;
      chk("retired_3", retired, 32'd3);
      chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_data = 16'hBEEF;
      tick();
      chk("idle_ignores_valid", {16'd0, bus.instr}, 32'h0005);
      bus.imem_valid = 1'b0;

      run_one(16'hE302, 1'b1, 1'b0, 0, 5'b00010);
      run_one(16'hE302, 1'b0, 1'b0, 0, 5'b00001);
      run_one(16'hE304, 1'b0, 1'b1, 0, 5'b00010);
      run_one(16'hE301, 1'b0, 1'b0, 0, 5'b00010);
      run_one(16'hE301, 1'b0, 1'b1, 0, 5'b00001);
      run_one(16'hE307, 1'b1, 1'b0, 0, 5'b00010);
      run_one(16'hE310, 1'b0, 1'b0, 0, 5'b01001);
      run_one(16'hE328, 1'b0, 1'b0, 3, 5'b10101);
      run_one(16'h1234, 1'b1, 1'b1, 1, 5'b10001);

      // run dropped in first FETCH, imem_valid two cycles later, then resume.
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      tick();
      chk("fetch_wait_req", {31'd0, bus.imem_req}, 32'd1);
      sb.push_back({16'h0ABC, 5'b10001});
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'h0ABC;
      tick();
      bus.imem_valid = 1'b0;
      tick();
      exp_ret++;
      chk("late_retired", retired, exp_ret);
      chk("late_idle_req", {31'd0, bus.imem_req}, 32'd0);
      run = 1'b1;
      tick();
      chk("resume_req", {31'd0, bus.imem_req}, 32'd1);
      run = 1'b0;
      sb.push_back({16'h0007, 5'b10001});
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'h0007;
      tick();
      bus.imem_valid = 1'b0;
      tick();
      exp_ret++;
      chk("resume_retired", retired, exp_ret);

      // Reset while EXEC would commit.
      run = 1'b1;
      tick();
      run            = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'h0009;
      tick();
      bus.imem_valid = 1'b0;
      reset          = 1'b1;
      @(negedge clk);
      chk("reset_exec_strobes", {24'd0, strobes()}, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_exec_boot", {24'd0, strobes()}, 32'h80);
      chk("reset_exec_retired", retired, 32'd0);
      chk("reset_exec_instr", {16'd0, bus.instr}, 32'd0);
      tick();

      // Fetch timeout into FAULT.
      run = 1'b1;
      tick();
      cyc = 0;
      while (!fault && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("timeout_cycles", cyc, 32'd4);
      chk("fault_set", {31'd0, fault}, 32'd1);
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fault_strobes", {24'd0, strobes()}, 32'd0);
         chk("fault_sticky", {31'd0, fault}, 32'd1);
      end
      chk("fault_instr", {16'd0, bus.instr}, 32'd0);
      bus.imem_valid = 1'b0;
      run            = 1'b0;
      reset          = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("fault_cleared", {31'd0, fault}, 32'd0);
      chk("fault_reset_boot", {24'd0, strobes()}, 32'h80);
      tick();
      tick();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
